// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int NB = 16;
  localparam logic [7:0] AES_AFFINE_C = 8'h63;

  typedef logic [7:0]      byte_t;
  typedef logic [8*NB-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fsm_e;

  // Byte 0 is the most significant byte of the state.
  function automatic int unsigned byte_lsb(input int unsigned i);
    return 8 * (NB - 1 - i);
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = b[i] ? (p ^ aa) : p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128); zero maps to zero.
  function automatic byte_t gf_inv(input byte_t x);
    byte_t r;
    byte_t s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// sbox_byte: combinational AES S-box, GF(2^8) inverse followed by the affine map.
module sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] inv;

  assign inv = gf_inv(data_i);

  // Affine map: inverse XOR its four left rotations, plus the 0x63 constant.
  always_comb data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ AES_AFFINE_C;

endmodule

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: byte-serial SubBytes through one shared S-box.
// Define SUB_BYTES_SBOX_REG_EN to register the S-box output (adds a DRAIN cycle).
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NB = aes_pkg::NB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*NB-1:0] state_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*NB-1:0] state_out,
  output logic            busy
);

  localparam int W  = 8 * NB;
  localparam int IW = $clog2(NB);

  fsm_e          state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  in_buf_q;
  logic [W-1:0]  out_buf_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [7:0]    sbox_in;
  logic [7:0]    sbox_out;
`ifdef SUB_BYTES_SBOX_REG_EN
  logic [7:0]    sbox_q;
`endif

  assign sbox_in   = in_buf_q[byte_lsb(32'(idx_q)) +: 8];
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = out_buf_q;

  sbox_byte u_sbox (
    .data_i (sbox_in),
    .data_o (sbox_out)
  );

  // Controller: accept a state, walk idx over all bytes, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_buf_q    <= '0;
      out_buf_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUB_BYTES_SBOX_REG_EN
      sbox_q      <= '0;
`endif
    end else begin
`ifdef SUB_BYTES_SBOX_REG_EN
      sbox_q <= sbox_out;
`endif
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_buf_q   <= state_in;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
`ifdef SUB_BYTES_SBOX_REG_EN
          if (idx_q != '0) out_buf_q[byte_lsb(32'(idx_q) - 32'd1) +: 8] <= sbox_q;
`else
          out_buf_q[byte_lsb(32'(idx_q)) +: 8] <= sbox_out;
`endif
          if (idx_q == IW'(NB - 1)) begin
`ifdef SUB_BYTES_SBOX_REG_EN
            state_q     <= DRAIN;
`else
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`endif
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
`ifdef SUB_BYTES_SBOX_REG_EN
        DRAIN: begin
          out_buf_q[byte_lsb(NB - 1) +: 8] <= sbox_q;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: randomized and directed checks of sub_bytes_seq against a table-driven S-box model.
module tb_sub_bytes_seq;

`ifdef SUB_BYTES_SBOX_REG_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [127:0] state_in;
  logic [127:0] state_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sbt[256];
  int acc_q[$];
  logic [127:0] out_q[$];

  sub_bytes_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accept edges and completed output handshakes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) out_q.push_back(state_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Polynomial product reduced modulo 0x11b using plain integer arithmetic.
  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p ^= a << i;
    for (int k = 14; k >= 8; k--) if (((p >> k) & 1) != 0) p ^= 'h11b << (k - 8);
    return p;
  endfunction

  // S-box table: brute-force inverse search, then the bitwise affine rule.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      for (int i = 0; i < 8; i++) begin
        int b = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s |= b << i;
      end
      sbt[x] = s;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'(sbt[s[127-8*i -: 8]])};
    return r;
  endfunction

  // Drive one state once idle; return the result and accept-to-valid edge count (accept edge counts as 1).
  task automatic xact(input logic [127:0] s, output logic [127:0] res, output int lat);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    state_in = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = state_out;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, state_out} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/busy/out got %b%b%b %h expected 100 0", in_ready, out_valid, busy, state_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: rdy/vld/busy got %b%b%b expected 100", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_vectors();
    logic [127:0] vin [5] = '{128'h0, 128'h00112233445566778899aabbccddeeff, {16{8'hff}},
                              {16{8'h01}}, 128'h00000000000000530000000000000000};
    logic [127:0] vexp[5] = '{{16{8'h63}}, 128'h638293c31bfc33f5c4eeacea4bc12816, {16{8'h16}},
                              {16{8'h7c}}, 128'h63636363636363ed6363636363636363};
    logic [127:0] res;
    int lat;
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      xact(vin[v], res, lat);
      checks++;
      if (res !== vexp[v]) begin
        errors++;
        $display("FAIL vector%0d_data: got %h expected %h", v, res, vexp[v]);
      end
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL vector%0d_latency: got %0d edges expected %0d", v, lat, LAT);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        errors++;
        $display("FAIL vector%0d_handshake: vld/rdy/busy got %b%b%b expected 010", v, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] s;
    logic [127:0] res;
    int lat;
    out_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      xact(s, res, lat);
      checks++;
      if (res !== model(s) || lat != LAT) begin
        errors++;
        $display("FAIL random%0d: in %h got %h lat %0d expected %h lat %0d", r, s, res, lat, model(s), LAT);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] d;
    logic [127:0] snap;
    int n = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    state_in = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    state_in = ~d;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    snap = state_out;
    checks++;
    if (snap !== model(d)) begin
      errors++;
      $display("FAIL bp_data: got %h expected %h", snap, model(d));
    end
    in_valid = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, state_out} !== {1'b1, 1'b0, model(d)}) begin
        errors++;
        $display("FAIL bp_hold%0d: vld/rdy got %b%b out %h expected 10 %h", c, out_valid, in_ready, state_out, model(d));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: vld/rdy/busy got %b%b%b expected 010", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    int n = 0;
    out_ready = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    state_in = {$urandom | 32'h1, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, state_out} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL midreset_async: rdy/vld/busy/out got %b%b%b %h expected 100 0", in_ready, out_valid, busy, state_out);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold%0d: out_valid got %b expected 0", c, out_valid);
      end
    end
    rst_n = 1'b1;
    xact(128'h0, res, lat);
    checks++;
    if (res !== {16{8'h63}} || lat != LAT) begin
      errors++;
      $display("FAIL midreset_recover: got %h lat %0d expected %h lat %0d", res, lat, {16{8'h63}}, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    int n = 0;
    int gap;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    acc_q.delete();
    out_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = a;
    while (acc_q.size() < 1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    state_in = b;
    while (acc_q.size() < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    while (out_q.size() < 2 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    gap = (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1;
    checks++;
    if (gap != LAT + 1) begin
      errors++;
      $display("FAIL b2b_gap: got %0d edges expected %0d", gap, LAT + 1);
    end
    checks++;
    if (out_q.size() < 2 || out_q[0] !== model(a) || out_q[1] !== model(b)) begin
      errors++;
      $display("FAIL b2b_data: got %0d results first %h expected %h then %h", out_q.size(),
               (out_q.size() > 0) ? out_q[0] : 128'h0, model(a), model(b));
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
